// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: routes two requesters onto a bank of dual-port SRAM macros.
// Conflicts are resolved round-robin; everything else is granted in the same cycle.
module sram_bank_arbiter #(
    parameter int NUM_BANKS       = 4,
    parameter int BANK_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_WMASKS      = 4,
    parameter bit INTERLEAVED     = 1'b0,
    parameter int ADDR_WIDTH      = BANK_ADDR_WIDTH + $clog2(NUM_BANKS)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  a_req_i,
    output logic                                  a_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                 a_addr_i,
    input  logic                                  a_we_i,
    input  logic [NUM_WMASKS-1:0]                 a_be_i,
    input  logic [DATA_WIDTH-1:0]                 a_wdata_i,
    output logic                                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 a_rdata_o,
    input  logic                                  b_req_i,
    output logic                                  b_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                 b_addr_i,
    input  logic                                  b_we_i,
    input  logic [NUM_WMASKS-1:0]                 b_be_i,
    input  logic [DATA_WIDTH-1:0]                 b_wdata_i,
    output logic                                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 b_rdata_o,
    output logic [NUM_BANKS-1:0]                  sram_clk0_o,
    output logic [NUM_BANKS-1:0]                  sram_clk1_o,
    output logic [NUM_BANKS-1:0]                  sram_csb0_o,
    output logic [NUM_BANKS-1:0]                  sram_web0_o,
    output logic [NUM_BANKS*NUM_WMASKS-1:0]       sram_wmask0_o,
    output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0]  sram_addr0_o,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]       sram_din0_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]       sram_dout0_i,
    output logic [NUM_BANKS-1:0]                  sram_csb1_o,
    output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0]  sram_addr1_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]       sram_dout1_i
);
    localparam int BW = $clog2(NUM_BANKS);

    logic [BW-1:0]              a_bank, b_bank, a_bank_q, b_bank_q;
    logic [BANK_ADDR_WIDTH-1:0] a_row, b_row;
    logic                       conflict, prio, a_we_q, b_we_q;

    if (INTERLEAVED) begin : g_lsb
        assign a_bank = a_addr_i[BW-1:0];
        assign b_bank = b_addr_i[BW-1:0];
        assign a_row  = a_addr_i[ADDR_WIDTH-1:BW];
        assign b_row  = b_addr_i[ADDR_WIDTH-1:BW];
    end else begin : g_msb
        assign a_bank = a_addr_i[ADDR_WIDTH-1 -: BW];
        assign b_bank = b_addr_i[ADDR_WIDTH-1 -: BW];
        assign a_row  = a_addr_i[BANK_ADDR_WIDTH-1:0];
        assign b_row  = b_addr_i[BANK_ADDR_WIDTH-1:0];
    end

    // B reads live on port 1, so only port-0 sharing or a same-word read-during-write collide
    assign conflict = a_req_i && b_req_i && a_bank == b_bank &&
                      (b_we_i || (a_we_i && a_row == b_row));
    assign a_gnt_o  = a_req_i && (!conflict || !prio);
    assign b_gnt_o  = b_req_i && (!conflict || prio);

    assign sram_clk0_o = {NUM_BANKS{clk_i}};
    assign sram_clk1_o = {NUM_BANKS{clk_i}};

    always_comb begin
        sram_csb0_o   = '1;
        sram_web0_o   = '1;
        sram_wmask0_o = '0;
        sram_addr0_o  = '0;
        sram_din0_o   = '0;
        sram_csb1_o   = '1;
        sram_addr1_o  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (a_gnt_o && a_bank == BW'(k)) begin
                sram_csb0_o[k]                                        = 1'b0;
                sram_web0_o[k]                                        = !a_we_i;
                sram_wmask0_o[k*NUM_WMASKS +: NUM_WMASKS]             = a_be_i;
                sram_addr0_o[k*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]    = a_row;
                sram_din0_o[k*DATA_WIDTH +: DATA_WIDTH]               = a_wdata_i;
            end else if (b_gnt_o && b_we_i && b_bank == BW'(k)) begin
                sram_csb0_o[k]                                        = 1'b0;
                sram_web0_o[k]                                        = 1'b0;
                sram_wmask0_o[k*NUM_WMASKS +: NUM_WMASKS]             = b_be_i;
                sram_addr0_o[k*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]    = b_row;
                sram_din0_o[k*DATA_WIDTH +: DATA_WIDTH]               = b_wdata_i;
            end
            if (b_gnt_o && !b_we_i && b_bank == BW'(k)) begin
                sram_csb1_o[k]                                        = 1'b0;
                sram_addr1_o[k*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]    = b_row;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio       <= 1'b0;
            a_rvalid_o <= 1'b0;
            b_rvalid_o <= 1'b0;
            a_bank_q   <= '0;
            b_bank_q   <= '0;
            a_we_q     <= 1'b0;
            b_we_q     <= 1'b0;
        end else begin
            prio       <= conflict ? !prio : prio;
            a_rvalid_o <= a_gnt_o;
            b_rvalid_o <= b_gnt_o;
            a_bank_q   <= a_bank;
            b_bank_q   <= b_bank;
            a_we_q     <= a_we_i;
            b_we_q     <= b_we_i;
        end
    end

    // B's port is implied by its registered write flag: reads came from port 1
    assign a_rdata_o = (a_rvalid_o && !a_we_q) ? sram_dout0_i[a_bank_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_rdata_o = (b_rvalid_o && !b_we_q) ? sram_dout1_i[b_bank_q*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: directed checks of the arbiter against behavioural SRAM macros.
// A second instance exercises the interleaved bank mapping.
module tb_sram_bank_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_init = 1'b1;
    int           errors = 0;
    int           checks = 0;

    logic         a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [10:0]  a_addr = 0, b_addr = 0;
    logic [3:0]   a_be = 0, b_be = 0;
    logic [31:0]  a_wdata = 0, b_wdata = 0;
    logic         a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0]  a_rdata, b_rdata;
    logic [3:0]   clk0, clk1, csb0, web0, csb1;
    logic [15:0]  wmask0;
    logic [35:0]  addr0, addr1;
    logic [127:0] din0, dout0, dout1;

    logic         ib_req = 0;
    logic [10:0]  ib_addr = 0;
    logic         i_a_gnt, i_b_gnt, i_a_rvalid, i_b_rvalid;
    logic [31:0]  i_a_rdata, i_b_rdata;
    logic [3:0]   i_clk0, i_clk1, i_csb0, i_web0, i_csb1;
    logic [15:0]  i_wmask0;
    logic [35:0]  i_addr0, i_addr1;
    logic [127:0] i_din0;

    logic [31:0]  mem [4][512];

    always #5 clk = ~clk;

    sram_bank_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_gnt_o(a_gnt), .a_addr_i(a_addr), .a_we_i(a_we), .a_be_i(a_be),
        .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_gnt_o(b_gnt), .b_addr_i(b_addr), .b_we_i(b_we), .b_be_i(b_be),
        .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .sram_clk0_o(clk0), .sram_clk1_o(clk1), .sram_csb0_o(csb0), .sram_web0_o(web0),
        .sram_wmask0_o(wmask0), .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0),
        .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1)
    );

    sram_bank_arbiter #(.INTERLEAVED(1'b1)) dut_il (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(1'b0), .a_gnt_o(i_a_gnt), .a_addr_i(11'h0), .a_we_i(1'b0), .a_be_i(4'h0),
        .a_wdata_i(32'h0), .a_rvalid_o(i_a_rvalid), .a_rdata_o(i_a_rdata),
        .b_req_i(ib_req), .b_gnt_o(i_b_gnt), .b_addr_i(ib_addr), .b_we_i(b_we), .b_be_i(b_be),
        .b_wdata_i(b_wdata), .b_rvalid_o(i_b_rvalid), .b_rdata_o(i_b_rdata),
        .sram_clk0_o(i_clk0), .sram_clk1_o(i_clk1), .sram_csb0_o(i_csb0), .sram_web0_o(i_web0),
        .sram_wmask0_o(i_wmask0), .sram_addr0_o(i_addr0), .sram_din0_o(i_din0), .sram_dout0_i(128'h0),
        .sram_csb1_o(i_csb1), .sram_addr1_o(i_addr1), .sram_dout1_i(128'h0)
    );

    // Macro model: synchronous read data appears after the clock edge, masked byte writes.
    // Every word starts as 0x1000_0000 | bank<<16 | row.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_init) begin
                for (int r = 0; r < 512; r++) mem[k][r] <= 32'h1000_0000 | (k << 16) | r;
            end else begin
                if (!csb0[k]) begin
                    if (!web0[k]) begin
                        for (int j = 0; j < 4; j++)
                            if (wmask0[k*4+j]) mem[k][addr0[k*9 +: 9]][j*8 +: 8] <= din0[k*32+j*8 +: 8];
                    end else begin
                        dout0[k*32 +: 32] <= mem[k][addr0[k*9 +: 9]];
                    end
                end
                if (!csb1[k]) dout1[k*32 +: 32] <= mem[k][addr1[k*9 +: 9]];
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_req = 0; b_req = 0; ib_req = 0; a_we = 0; b_we = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        mem_init = 1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", a_rvalid, b_rvalid); end
        checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h want 0 0", a_rdata, b_rdata); end
        checks++; if (csb0 !== 4'hF || csb1 !== 4'hF || web0 !== 4'hF) begin errors++; $display("FAIL rst_csb: got csb0=%b csb1=%b web0=%b want 1111", csb0, csb1, web0); end
        checks++; if (wmask0 !== 16'h0 || addr0 !== 36'h0 || din0 !== 128'h0 || addr1 !== 36'h0) begin errors++; $display("FAIL rst_pins: nonzero idle pins"); end
        checks++; if (clk0 !== {4{clk}} || clk1 !== {4{clk}}) begin errors++; $display("FAIL rst_clk: got %b %b want %b", clk0, clk1, {4{clk}}); end
        mem_init = 0;
        #1 rst_n = 1;
    endtask

    task automatic test_write_read;
        cyc; a_req = 1; a_we = 1; a_addr = 11'h005; a_be = 4'hF; a_wdata = 32'hDEADBEEF; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", a_gnt); end
        checks++; if (csb0 !== 4'b1110 || web0 !== 4'b1110) begin errors++; $display("FAIL wr_pins: got csb0=%b web0=%b want 1110 1110", csb0, web0); end
        checks++; if (addr0[8:0] !== 9'h005 || din0[31:0] !== 32'hDEADBEEF || wmask0[3:0] !== 4'hF) begin errors++; $display("FAIL wr_bus: got addr=%h din=%h mask=%h", addr0[8:0], din0[31:0], wmask0[3:0]); end
        cyc; a_we = 0; #1;
        checks++; if (a_gnt !== 1'b1 || a_rvalid !== 1'b1) begin errors++; $display("FAIL wr_resp: got gnt=%b rvalid=%b want 1 1", a_gnt, a_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", a_rdata); end
        cyc; idle; #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got rvalid=%b rdata=%h want 1 deadbeef", a_rvalid, a_rdata); end
        cyc; #1;
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin errors++; $display("FAIL rd_idle: got rvalid=%b rdata=%h want 0 0", a_rvalid, a_rdata); end
    endtask

    task automatic test_dual_read;
        cyc; a_req = 1; b_req = 1; a_addr = 11'h010; b_addr = 11'h010; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b1) begin errors++; $display("FAIL dual_gnt: got %b%b want 11", a_gnt, b_gnt); end
        checks++; if (csb0 !== 4'b1110 || csb1 !== 4'b1110) begin errors++; $display("FAIL dual_ports: got csb0=%b csb1=%b want 1110 1110", csb0, csb1); end
        cyc; idle; #1;
        checks++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b1) begin errors++; $display("FAIL dual_rvalid: got %b%b want 11", a_rvalid, b_rvalid); end
        checks++; if (a_rdata !== 32'h1000_0010 || b_rdata !== 32'h1000_0010) begin errors++; $display("FAIL dual_rdata: got %h %h want 10000010", a_rdata, b_rdata); end
    endtask

    task automatic test_conflict_rw;
        cyc; a_req = 1; a_we = 1; a_addr = 11'h020; a_be = 4'hF; a_wdata = 32'hCAFEF00D;
        b_req = 1; b_we = 0; b_addr = 11'h020; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL rw_c1: got %b%b want 10", a_gnt, b_gnt); end
        cyc; #1;
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin errors++; $display("FAIL rw_c2: got %b%b want 01", a_gnt, b_gnt); end
        checks++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rw_c2_rv: got %b%b want 10", a_rvalid, b_rvalid); end
        cyc; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL rw_c3: got %b%b want 10", a_gnt, b_gnt); end
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_bdata: got rvalid=%b rdata=%h want 1 cafef00d", b_rvalid, b_rdata); end
        cyc; #1;
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin errors++; $display("FAIL rw_c4: got %b%b want 01", a_gnt, b_gnt); end
        cyc; idle; #1;
        checks++; if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rw_c5_rv: got a=%b b=%b want 0 1", a_rvalid, b_rvalid); end
    endtask

    task automatic test_no_conflict_diff_row;
        cyc; a_req = 1; a_we = 1; a_addr = 11'h030; a_be = 4'hF; a_wdata = 32'h12345678;
        b_req = 1; b_we = 0; b_addr = 11'h031; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b1) begin errors++; $display("FAIL diffrow_gnt: got %b%b want 11", a_gnt, b_gnt); end
        checks++; if (csb0 !== 4'b1110 || csb1 !== 4'b1110 || addr1[8:0] !== 9'h031) begin errors++; $display("FAIL diffrow_pins: got csb0=%b csb1=%b addr1=%h", csb0, csb1, addr1[8:0]); end
        cyc; idle; #1;
        checks++; if (b_rdata !== 32'h1000_0031 || a_rdata !== 32'h0) begin errors++; $display("FAIL diffrow_rdata: got b=%h a=%h want 10000031 0", b_rdata, a_rdata); end
    endtask

    task automatic test_be_zero;
        cyc; a_req = 1; a_we = 1; a_addr = 11'h005; a_be = 4'h0; a_wdata = 32'h0; #1;
        checks++; if (a_gnt !== 1'b1 || wmask0[3:0] !== 4'h0) begin errors++; $display("FAIL be0_gnt: got gnt=%b mask=%h want 1 0", a_gnt, wmask0[3:0]); end
        cyc; a_we = 0; #1;
        checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL be0_resp: got %b want 1", a_rvalid); end
        cyc; idle; #1;
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL be0_keep: got %h want deadbeef", a_rdata); end
    endtask

    task automatic test_write_write;
        cyc; a_req = 1; a_we = 1; a_addr = 11'h203; a_be = 4'hF; a_wdata = 32'h11111111;
        b_req = 1; b_we = 1; b_addr = 11'h207; b_be = 4'hF; b_wdata = 32'h22222222; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL ww_c1: got %b%b want 10", a_gnt, b_gnt); end
        checks++; if (csb0 !== 4'b1101 || addr0[17:9] !== 9'h003 || din0[63:32] !== 32'h11111111) begin errors++; $display("FAIL ww_c1_pins: got csb0=%b addr=%h din=%h", csb0, addr0[17:9], din0[63:32]); end
        cyc; #1;
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin errors++; $display("FAIL ww_c2: got %b%b want 01", a_gnt, b_gnt); end
        checks++; if (csb0 !== 4'b1101 || web0 !== 4'b1101 || addr0[17:9] !== 9'h007 || din0[63:32] !== 32'h22222222) begin errors++; $display("FAIL ww_c2_pins: got csb0=%b web0=%b addr=%h din=%h", csb0, web0, addr0[17:9], din0[63:32]); end
        cyc; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL ww_c3: got %b%b want 10", a_gnt, b_gnt); end
        cyc; idle; a_req = 1; b_req = 1; a_addr = 11'h207; b_addr = 11'h203; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b1 || csb0 !== 4'b1101 || csb1 !== 4'b1101) begin errors++; $display("FAIL ww_rd_gnt: got %b%b csb0=%b csb1=%b", a_gnt, b_gnt, csb0, csb1); end
        cyc; idle; #1;
        checks++; if (a_rdata !== 32'h22222222 || b_rdata !== 32'h11111111) begin errors++; $display("FAIL ww_rdata: got %h %h want 22222222 11111111", a_rdata, b_rdata); end
    endtask

    task automatic test_interleaved;
        int rv = 0;
        logic [3:0] exp;
        b_we = 1; b_be = 4'hF; b_wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 8; i++) begin
            cyc; ib_req = 1; ib_addr = 11'(i); #1;
            exp = ~(4'b0001 << (i % 4));
            checks++; if (i_b_gnt !== 1'b1 || i_csb0 !== exp) begin errors++; $display("FAIL il_walk%0d: got gnt=%b csb0=%b want 1 %b", i, i_b_gnt, i_csb0, exp); end
            if (i_b_rvalid === 1'b1) rv++;
        end
        cyc; idle; #1;
        if (i_b_rvalid === 1'b1) rv++;
        checks++; if (rv !== 8) begin errors++; $display("FAIL il_rvalids: got %0d want 8", rv); end
        cyc; #1;
        checks++; if (i_b_rvalid !== 1'b0) begin errors++; $display("FAIL il_done: got %b want 0", i_b_rvalid); end
    endtask

    task automatic test_reset_mid;
        cyc; a_req = 1; a_we = 0; a_addr = 11'h005; #1;
        checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", a_gnt); end
        cyc; idle; rst_n = 0; #1;
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin errors++; $display("FAIL rm_drop: got rvalid=%b rdata=%h want 0 0", a_rvalid, a_rdata); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc; #1;
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || csb0 !== 4'hF || csb1 !== 4'hF) begin errors++; $display("FAIL rm_idle: got rv=%b%b csb0=%b csb1=%b", a_rvalid, b_rvalid, csb0, csb1); end
        cyc; a_req = 1; a_we = 1; a_addr = 11'h040; a_be = 4'hF; b_req = 1; b_we = 0; b_addr = 11'h040; #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL rm_prio: got %b%b want 10", a_gnt, b_gnt); end
        cyc; idle; #1;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_dual_read;
        test_conflict_rw;
        test_no_conflict_diff_row;
        test_be_zero;
        test_write_write;
        test_interleaved;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
